// File: rtl/snn_layer_if.sv
// Bus between spike encoder, neuron layer and read-out.
// Carries the sample clock-phase, spike times and winner result.
interface snn_layer_if #(
  parameter int NUM_SPIKES     = 8,
  parameter int NUM_NEURONS    = 4,
  parameter int TIME_PERIOD    = 24,
  parameter int TESTING_PERIOD = 8
);
  localparam int LTP = $clog2(TESTING_PERIOD);
  localparam int LTM = $clog2(TIME_PERIOD);
  localparam int LN  = $clog2(NUM_NEURONS);

  logic                            training;
  logic [LTM:0]                    time_val;
  logic [NUM_SPIKES-1:0][LTP:0]    spike_times;
  logic [LTP:0]                    output_spike_time;
  logic [LN:0]                     winning_neuron;

  modport master (
    output training, time_val, spike_times,
    input  output_spike_time, winning_neuron
  );

  modport slave (
    input  training, time_val, spike_times,
    output output_spike_time, winning_neuron
  );
endinterface

// File: rtl/snn_layer.sv
// Integrate-and-fire temporal neuron layer with
// winner-take-all and single-winner STDP training.
module snn_layer #(
  parameter int NUM_SPIKES     = 8,
  parameter int NUM_NEURONS    = 4,
  parameter int TIME_PERIOD    = 24,
  parameter int TESTING_PERIOD = 8,
  parameter int WEIGHT_W       = 3,
  parameter int THRESHOLD      = 12
) (
  input logic        clk,
  input logic        rst_l,
  snn_layer_if.slave bus
);
  localparam int LTP  = $clog2(TESTING_PERIOD);
  localparam int LTM  = $clog2(TIME_PERIOD);
  localparam int LN   = $clog2(NUM_NEURONS);
  localparam int WMAX = (1 << WEIGHT_W) - 1;
  localparam int PW   = $clog2(NUM_SPIKES * WMAX + 1);

  typedef logic [LN:0]         nidx_t;
  typedef logic [LTP:0]        tp_t;
  typedef logic [PW-1:0]       pot_t;
  typedef logic [WEIGHT_W-1:0] w_t;

  localparam nidx_t NO_WIN  = nidx_t'(NUM_NEURONS);
  localparam tp_t   NO_TIME = tp_t'(TESTING_PERIOD);
  localparam pot_t  THR     = pot_t'(THRESHOLD);
  localparam w_t    WTOP    = w_t'(WMAX);

  logic [NUM_NEURONS-1:0][NUM_SPIKES-1:0][WEIGHT_W-1:0] w_q, w_d, w_init;
  logic [NUM_NEURONS-1:0][PW-1:0] pot_q, pot_d;
  nidx_t win_q, win_d;
  tp_t   ost_q, ost_d;

  logic [NUM_NEURONS-1:0] fire;
  logic [NUM_SPIKES-1:0]  hit;
  logic                   in_win;
  logic                   t_zero;
  logic                   stdp_en;
  logic                   fire_any;
  nidx_t                  fire_idx;

  // Window phase decode and input spike match for this cycle.
  always_comb begin
    in_win  = 32'(bus.time_val) < TESTING_PERIOD;
    t_zero  = bus.time_val == '0;
    stdp_en = (32'(bus.time_val) == TESTING_PERIOD) &&
              bus.training && (win_q != NO_WIN);
    for (int i = 0; i < NUM_SPIKES; i++) begin
      hit[i] = in_win &&
               (32'(bus.spike_times[i]) == 32'(bus.time_val));
    end
  end

  // Potential integration and fire detection per neuron.
  always_comb begin
    pot_d = pot_q;
    fire  = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (in_win) begin
        pot_d[n] = t_zero ? '0 : pot_q[n];
        for (int i = 0; i < NUM_SPIKES; i++) begin
          if (hit[i]) pot_d[n] = pot_d[n] + pot_t'(w_q[n][i]);
        end
        fire[n] = pot_d[n] >= THR;
      end
    end
  end

  // Lowest-index firing neuron wins.
  always_comb begin
    fire_any = |fire;
    fire_idx = NO_WIN;
    for (int n = NUM_NEURONS - 1; n >= 0; n--) begin
      if (fire[n]) fire_idx = nidx_t'(n);
    end
  end

  // Winner capture: reload at window start, then first fire only.
  always_comb begin
    win_d = win_q;
    ost_d = ost_q;
    if (in_win && t_zero) begin
      win_d = fire_idx;
      ost_d = fire_any ? '0 : NO_TIME;
    end else if (in_win && win_q == NO_WIN && fire_any) begin
      win_d = fire_idx;
      ost_d = tp_t'(bus.time_val);
    end
  end

  // STDP on the winner row: potentiate causal inputs, depress the rest.
  always_comb begin
    w_d = w_q;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (stdp_en && nidx_t'(n) == win_q) begin
        for (int i = 0; i < NUM_SPIKES; i++) begin
          if (bus.spike_times[i] <= ost_q) begin
            if (w_q[n][i] != WTOP) w_d[n][i] = w_q[n][i] + 1'b1;
          end else begin
            if (w_q[n][i] != '0) w_d[n][i] = w_q[n][i] - 1'b1;
          end
        end
      end
    end
  end

  // Initial weight pattern (n+i) wrapped to the weight range.
  always_comb begin
    for (int n = 0; n < NUM_NEURONS; n++) begin
      for (int i = 0; i < NUM_SPIKES; i++) begin
        w_init[n][i] = w_t'(n + i);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_l) begin
      pot_q <= '0;
      win_q <= NO_WIN;
      ost_q <= NO_TIME;
      w_q   <= w_init;
    end else begin
      pot_q <= pot_d;
      win_q <= win_d;
      ost_q <= ost_d;
      w_q   <= w_d;
    end
  end

  assign bus.output_spike_time = ost_q;
  assign bus.winning_neuron    = win_q;
endmodule

// File: tb/tb_snn_layer.sv
// Directed scoreboard bench for snn_layer.
// Model predicts winner/time and tracks STDP weights.
module tb_snn_layer;
  localparam int NS = 8;
  localparam int NN = 4;
  localparam int TP = 8;
  localparam int TM = 24;

  typedef struct {
    int w;
    int t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_l;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   sp[NS];
  int   wm[NN][NS];
  int   ew;
  int   et;
  exp_t sb[$];

  snn_layer_if #(
    .NUM_SPIKES(NS), .NUM_NEURONS(NN),
    .TIME_PERIOD(TM), .TESTING_PERIOD(TP)
  ) bus ();

  snn_layer #(
    .NUM_SPIKES(NS), .NUM_NEURONS(NN),
    .TIME_PERIOD(TM), .TESTING_PERIOD(TP),
    .WEIGHT_W(3), .THRESHOLD(12)
  ) dut (
    .clk(clk),
    .rst_l(rst_l),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input int exp);
    n_assert++;
    assert (obs === 32'(exp)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic init_wm();
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < NS; i++)
        wm[n][i] = (n + i) % 8;
  endtask

  task automatic check_weights(input string tag);
    for (int n = 0; n < NN; n++)
      for (int i = 0; i < NS; i++)
        check($sformatf("%s w[%0d][%0d]", tag, n, i),
              32'(dut.w_q[n][i]), wm[n][i]);
  endtask

  task automatic set_sp(input int a);
    for (int i = 0; i < NS; i++) sp[i] = a;
  endtask

  task automatic predict();
    int pot[NN];
    ew = NN;
    et = TP;
    for (int n = 0; n < NN; n++) pot[n] = 0;
    for (int t = 0; t < TP; t++) begin
      for (int n = 0; n < NN; n++)
        for (int i = 0; i < NS; i++)
          if (sp[i] == t) pot[n] += wm[n][i];
      if (ew == NN) begin
        for (int n = NN - 1; n >= 0; n--)
          if (pot[n] >= 12) begin
            ew = n;
            et = t;
          end
      end
    end
  endtask

  task automatic cyc(input string tag, input int t);
    exp_t e;
    bus.time_val = 6'(t);
    e.w = (et <= t) ? ew : NN;
    e.t = (et <= t) ? et : TP;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 32'd1, 0);
    end else begin
      e = sb.pop_front();
      check($sformatf("%s t%0d win", tag, t),
            32'(bus.winning_neuron), e.w);
      check($sformatf("%s t%0d time", tag, t),
            32'(bus.output_spike_time), e.t);
    end
  endtask

  task automatic sample(input string tag, input bit tr);
    predict();
    bus.training = tr;
    for (int i = 0; i < NS; i++) bus.spike_times[i] = 4'(sp[i]);
    for (int t = 0; t < (tr ? TM : TP); t++) cyc(tag, t);
    if (tr && ew != NN) begin
      for (int i = 0; i < NS; i++) begin
        if (sp[i] <= et) wm[ew][i] = (wm[ew][i] < 7) ? wm[ew][i] + 1 : 7;
        else             wm[ew][i] = (wm[ew][i] > 0) ? wm[ew][i] - 1 : 0;
      end
    end
    check_weights(tag);
  endtask

  initial begin
    rst_l = 1'b1;
    bus.training = 1'b0;
    bus.time_val = '0;
    set_sp(8);
    for (int i = 0; i < NS; i++) bus.spike_times[i] = 4'(sp[i]);
    init_wm();
    repeat (2) @(posedge clk);
    #1;
    check("rst win", 32'(bus.winning_neuron), 4);
    check("rst time", 32'(bus.output_spike_time), 8);
    check_weights("rst");
    rst_l = 1'b0;

    set_sp(8);
    sample("idle_train", 1'b1);

    set_sp(12);
    sample("late_spikes", 1'b1);

    set_sp(8);
    sp[6] = 0;
    sp[7] = 0;
    sample("inf_67", 1'b0);

    set_sp(8);
    sp[0] = 3;
    sp[1] = 3;
    sp[2] = 3;
    sample("inf_012", 1'b0);

    set_sp(0);
    sample("inf_all", 1'b0);

    set_sp(8);
    sp[6] = 0;
    sp[7] = 0;
    sample("train_67", 1'b1);
    check("stdp w06", 32'(dut.w_q[0][6]), 7);
    check("stdp w07", 32'(dut.w_q[0][7]), 7);
    check("stdp w00", 32'(dut.w_q[0][0]), 0);
    check("stdp w05", 32'(dut.w_q[0][5]), 4);
    check("stdp w15", 32'(dut.w_q[1][5]), 6);

    sample("inf_67_again", 1'b0);

    predict();
    bus.training = 1'b1;
    for (int i = 0; i < NS; i++) bus.spike_times[i] = 4'(sp[i]);
    for (int t = 0; t < 4; t++) cyc("abort", t);
    bus.time_val = 6'd4;
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    rst_l = 1'b0;
    init_wm();
    check("abort win", 32'(bus.winning_neuron), 4);
    check("abort time", 32'(bus.output_spike_time), 8);
    check_weights("abort");

    set_sp(8);
    sp[0] = 3;
    sp[1] = 3;
    sp[2] = 3;
    sample("post_abort", 1'b0);

    check("sb drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
